// File: rtl/cramer_solver.sv
// cramer_solver: 3x3 Cramer's-rule solver, one shared determinant datapath and one restoring divider; CRAMER_SINGULAR_BYPASS_EN skips DIV when D==0.
// Latency 4+3*DW edges from acceptance (4 when singular with bypass); results held until out_ready, in_ready only while idle.
module cramer_solver #(
   parameter int W  = 3,
   parameter int DW = 3*W+3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  a1,
   input  logic [W-1:0]  b1,
   input  logic [W-1:0]  c1,
   input  logic [W-1:0]  d1,
   input  logic [W-1:0]  a2,
   input  logic [W-1:0]  b2,
   input  logic [W-1:0]  c2,
   input  logic [W-1:0]  d2,
   input  logic [W-1:0]  a3,
   input  logic [W-1:0]  b3,
   input  logic [W-1:0]  c3,
   input  logic [W-1:0]  d3,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] x1,
   output logic [DW-1:0] x2,
   output logic [DW-1:0] x3,
   output logic [2:0]    exact,
   output logic          singular,
   output logic [DW-1:0] det,
   output logic          out_valid,
   input  logic          out_ready
);
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, DET, DIV, DONE} state_t;

   state_t               state;
   logic [1:0]           step;
   logic [1:0]           div_idx;
   logic [CW-1:0]        it_cnt;
   logic [W-1:0]         ca [3];
   logic [W-1:0]         cb [3];
   logic [W-1:0]         cc [3];
   logic [W-1:0]         cd [3];
   logic signed [DW-1:0] dv [4];
   logic [DW-1:0]        rem;
   logic [DW-1:0]        quo;

   assign in_ready = (state == IDLE);

   // Step 1..3 swaps the RHS into column a, b, c respectively.
   logic signed [DW-1:0] ma [3];
   logic signed [DW-1:0] mb [3];
   logic signed [DW-1:0] mc [3];
   logic signed [DW-1:0] det_cur;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         ma[i] = (step == 2'd1) ? DW'(cd[i]) : DW'(ca[i]);
         mb[i] = (step == 2'd2) ? DW'(cd[i]) : DW'(cb[i]);
         mc[i] = (step == 2'd3) ? DW'(cd[i]) : DW'(cc[i]);
      end
      det_cur = ma[0] * (mb[1] * mc[2] - mb[2] * mc[1])
              - mb[0] * (ma[1] * mc[2] - ma[2] * mc[1])
              + mc[0] * (ma[1] * mb[2] - ma[2] * mb[1]);
   end

   function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] v);
      return v[DW-1] ? -v : v;
   endfunction

   // First iteration of each division loads |Di| directly, so each division costs exactly DW edges.
   logic signed [DW-1:0] dividend;
   logic [DW-1:0]        dmag;
   logic [DW-1:0]        rem_in;
   logic [DW-1:0]        quo_in;
   logic [DW:0]          shifted;
   logic                 ge;
   logic                 neg;
   logic [DW-1:0]        rem_nx;
   logic [DW-1:0]        quo_nx;
   logic [DW-1:0]        q_res;

   always_comb begin
      dividend = dv[div_idx + 2'd1];
      dmag     = mag(dv[0]);
      rem_in   = (it_cnt == '0) ? '0 : rem;
      quo_in   = (it_cnt == '0) ? mag(dividend) : quo;
      shifted  = {rem_in, quo_in[DW-1]};
      ge       = (shifted >= {1'b0, dmag});
      rem_nx   = ge ? DW'(shifted - {1'b0, dmag}) : shifted[DW-1:0];
      quo_nx   = {quo_in[DW-2:0], ge};
      neg      = dividend[DW-1] ^ dv[0][DW-1];
      q_res    = singular ? '0 : (neg ? -quo_nx : quo_nx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         step      <= '0;
         div_idx   <= '0;
         it_cnt    <= '0;
         rem       <= '0;
         quo       <= '0;
         for (int i = 0; i < 3; i++) begin
            ca[i] <= '0;
            cb[i] <= '0;
            cc[i] <= '0;
            cd[i] <= '0;
         end
         for (int i = 0; i < 4; i++) dv[i] <= '0;
         x1        <= '0;
         x2        <= '0;
         x3        <= '0;
         exact     <= '0;
         singular  <= 1'b0;
         det       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ca[0] <= a1; ca[1] <= a2; ca[2] <= a3;
                  cb[0] <= b1; cb[1] <= b2; cb[2] <= b3;
                  cc[0] <= c1; cc[1] <= c2; cc[2] <= c3;
                  cd[0] <= d1; cd[1] <= d2; cd[2] <= d3;
                  step  <= '0;
                  state <= DET;
               end
            end
            DET: begin
               dv[step] <= det_cur;
               step     <= step + 2'd1;
               if (step == 2'd0) det <= det_cur;
               if (step == 2'd3) begin
                  singular <= (dv[0] == '0);
                  div_idx  <= '0;
                  it_cnt   <= '0;
`ifdef CRAMER_SINGULAR_BYPASS_EN
                  if (dv[0] == '0) begin
                     x1        <= '0;
                     x2        <= '0;
                     x3        <= '0;
                     exact     <= '0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= DIV;
                  end
`else
                  state <= DIV;
`endif
               end
            end
            DIV: begin
               rem    <= rem_nx;
               quo    <= quo_nx;
               it_cnt <= it_cnt + 1'b1;
               if (it_cnt == CW'(DW-1)) begin
                  it_cnt          <= '0;
                  div_idx         <= div_idx + 2'd1;
                  exact[div_idx]  <= !singular && (rem_nx == '0);
                  case (div_idx)
                     2'd0:    x1 <= q_res;
                     2'd1:    x2 <= q_res;
                     default: x3 <= q_res;
                  endcase
                  if (div_idx == 2'd2) begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cramer_solver.sv
// Directed bench for cramer_solver: vector table plus stall and mid-division reset sequences.
module tb_cramer_solver;
   localparam int DW = 12;
   localparam int FULL_LAT = 40;
`ifdef CRAMER_SINGULAR_BYPASS_EN
   localparam int SING_LAT = 4;
`else
   localparam int SING_LAT = 40;
`endif

   typedef struct {
      logic [11:0][2:0] cf;
      int dt;
      int e1;
      int e2;
      int e3;
      int ex;
      int sg;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [11:0][2:0] cf = '0;
   logic in_ready, singular, out_valid;
   logic [DW-1:0] x1, x2, x3, det;
   logic [2:0] exact;

   int n_chk = 0;
   int n_err = 0;
   vec_t tbl [7];

   always #5 clk = ~clk;

   cramer_solver dut (
      .clk(clk), .rst(rst),
      .a1(cf[0]), .b1(cf[1]), .c1(cf[2]),  .d1(cf[3]),
      .a2(cf[4]), .b2(cf[5]), .c2(cf[6]),  .d2(cf[7]),
      .a3(cf[8]), .b3(cf[9]), .c3(cf[10]), .d3(cf[11]),
      .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .x2(x2), .x3(x3), .exact(exact), .singular(singular),
      .det(det), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   function automatic vec_t mk(input int r[12], input int dt, input int e1, input int e2,
                               input int e3, input int ex, input int sg);
      vec_t v;
      for (int i = 0; i < 12; i++) v.cf[i] = 3'(r[i]);
      v.dt = dt; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.ex = ex; v.sg = sg;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      @(negedge clk);
      cf = v.cf;
      in_valid = 1'b1;
      chk($sformatf("v%0d in_ready", idx), int'(in_ready), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      chk($sformatf("v%0d latency", idx), lat, (v.sg != 0) ? SING_LAT : FULL_LAT);
      chk($sformatf("v%0d det", idx), $signed(det), v.dt);
      chk($sformatf("v%0d x1", idx), $signed(x1), v.e1);
      chk($sformatf("v%0d x2", idx), $signed(x2), v.e2);
      chk($sformatf("v%0d x3", idx), $signed(x3), v.e3);
      chk($sformatf("v%0d exact", idx), int'(exact), v.ex);
      chk($sformatf("v%0d singular", idx), int'(singular), v.sg);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk($sformatf("v%0d out_valid drop", idx), int'(out_valid), 0);
      chk($sformatf("v%0d in_ready back", idx), int'(in_ready), 1);
   endtask

   initial begin
      int lat;
      int viol;

      tbl[0] = mk('{1,0,0,1, 0,1,0,2, 0,0,1,3},  1,  1, 2, 3, 7, 0);
      tbl[1] = mk('{1,2,3,1, 0,1,2,2, 0,0,1,3},  1,  0,-4, 3, 7, 0);
      tbl[2] = mk('{2,0,0,1, 0,3,0,2, 0,0,4,3}, 24,  0, 0, 0, 0, 0);
      tbl[3] = mk('{7,7,7,7, 7,7,7,7, 7,7,7,7},  0,  0, 0, 0, 0, 1);
      tbl[4] = mk('{2,1,0,0, 0,1,0,3, 0,0,1,0},  2, -1, 3, 0, 6, 0);
      tbl[5] = mk('{0,1,0,1, 1,0,0,2, 0,0,1,3}, -1,  2, 1, 3, 7, 0);
      tbl[6] = mk('{2,0,0,4, 0,2,0,6, 0,0,2,2},  8,  2, 3, 1, 7, 0);

      #2 rst = 1'b1;
      @(negedge clk);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset det", int'(det), 0);
      chk("reset x1", int'(x1), 0);
      chk("reset exact", int'(exact), 0);
      chk("reset singular", int'(singular), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post-reset in_ready", int'(in_ready), 1);

      for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

      // Stalled consumer, with stray in_valid pulses while dividing.
      @(negedge clk);
      cf = tbl[0].cf;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      viol = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         in_valid = (k == 10 || k == 25);
         if (in_valid) cf = '1;
         if (out_valid) begin
            lat = k;
            break;
         end
         if (in_ready) viol++;
      end
      in_valid = 1'b0;
      chk("stall latency", lat, FULL_LAT);
      chk("stall x1", $signed(x1), 1);
      chk("stall x2", $signed(x2), 2);
      chk("stall x3", $signed(x3), 3);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (!out_valid || in_ready || x1 != 12'd1 || x2 != 12'd2 || x3 != 12'd3 ||
             exact != 3'b111 || det != 12'd1) viol++;
      end
      chk("stall hold violations", viol, 0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("stall out_valid drop", int'(out_valid), 0);
      chk("stall in_ready back", int'(in_ready), 1);

      // Reset in the middle of the divider, then a fresh solve.
      @(negedge clk);
      cf = tbl[0].cf;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst out_valid", int'(out_valid), 0);
      chk("midrst det", int'(det), 0);
      chk("midrst x1", int'(x1), 0);
      chk("midrst x2", int'(x2), 0);
      chk("midrst exact", int'(exact), 0);
      chk("midrst singular", int'(singular), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("midrst in_ready", int'(in_ready), 1);
      run_vec(tbl[6], 7);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
